// File: rtl/seq.sv
// Free-running step sequencer: prescaled 3-bit sub-step phase (tick) and one-hot 8-way step select (sel).
// Define SEQ_PINGPONG_EN to make sel bounce between bit0 and bit7 instead of rotating.
//
//   dir  | meaning (SEQ_PINGPONG_EN only)
//   -----+----------------------------------------------
//   UP   | step advance shifts sel left (toward bit7)
//   DOWN | step advance shifts sel right (toward bit0)

module seq #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] tick,
  output logic [7:0] sel
);

  localparam int            CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] TC = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    tick_q, tick_d;
  logic [7:0]    sel_q, sel_d;
  logic          strobe;
  logic          advance;
  logic          sel_ok;

`ifdef SEQ_PINGPONG_EN
  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;
  logic dir_q, dir_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 3'd0;
      sel_q  <= 8'h01;
`ifdef SEQ_PINGPONG_EN
      dir_q  <= UP;
`endif
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sel_q  <= sel_d;
`ifdef SEQ_PINGPONG_EN
      dir_q  <= dir_d;
`endif
    end
  end

  assign strobe  = (cnt_q == TC);
  assign advance = strobe && (tick_q == 3'd7);
  assign sel_ok  = (sel_q != 8'd0) && ((sel_q & (sel_q - 8'd1)) == 8'd0);

  always_comb begin
    cnt_d  = strobe ? '0 : cnt_q + 1'b1;
    tick_d = strobe ? tick_q + 3'd1 : tick_q;
    sel_d  = sel_q;
`ifdef SEQ_PINGPONG_EN
    dir_d  = dir_q;
`endif
    if (advance) begin
`ifdef SEQ_PINGPONG_EN
      if (!sel_ok) begin
        sel_d = 8'h01;
        dir_d = UP;
      end else if ((dir_q == UP && !sel_q[7]) || sel_q[0]) begin
        // endpoints force the outward direction even if dir disagrees
        sel_d = {sel_q[6:0], 1'b0};
        dir_d = sel_d[7] ? DOWN : UP;
      end else begin
        sel_d = {1'b0, sel_q[7:1]};
        dir_d = sel_d[0] ? UP : DOWN;
      end
`else
      sel_d = sel_ok ? {sel_q[6:0], sel_q[7]} : 8'h01;
`endif
    end
  end

  always_comb begin
    tick = tick_q;
    sel  = sel_q;
  end

endmodule

// File: tb/tb_seq.sv
// Directed bench for seq: table of reset/prescale vectors on a PRESCALE=4 instance,
// plus a per-cycle walk of a PRESCALE=1 instance (rotation or ping-pong by build).

module tb_seq;

  logic       clk = 1'b0;
  logic       rst4 = 1'b1;
  logic       rst1 = 1'b1;
  logic [2:0] tick4, tick1;
  logic [7:0] sel4, sel1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq #(.PRESCALE(4)) u_seq4 (.clk(clk), .rst(rst4), .tick(tick4), .sel(sel4));
  seq #(.PRESCALE(1)) u_seq1 (.clk(clk), .rst(rst1), .tick(tick1), .sel(sel1));

  typedef struct {
    logic       rst;
    int         edges;
    logic [2:0] tick;
    logic [7:0] sel;
  } vec_t;

  vec_t tbl[16];
  logic [7:0] walk[15];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    // rst, edges, tick, sel -- edge counts are relative to the previous row
    tbl[0]  = '{1'b1, 1,  3'd0, 8'h01};
    tbl[1]  = '{1'b1, 1,  3'd0, 8'h01};
    tbl[2]  = '{1'b1, 1,  3'd0, 8'h01};
    tbl[3]  = '{1'b0, 3,  3'd0, 8'h01};  // edge 3
    tbl[4]  = '{1'b0, 1,  3'd1, 8'h01};  // edge 4
    tbl[5]  = '{1'b0, 4,  3'd2, 8'h01};  // edge 8
    tbl[6]  = '{1'b0, 20, 3'd7, 8'h01};  // edge 28
    tbl[7]  = '{1'b0, 3,  3'd7, 8'h01};  // edge 31
    tbl[8]  = '{1'b0, 1,  3'd0, 8'h02};  // edge 32
    tbl[9]  = '{1'b0, 32, 3'd0, 8'h04};  // edge 64
    tbl[10] = '{1'b0, 86, 3'd5, 8'h10};  // edge 150: prescaler at 2
    tbl[11] = '{1'b1, 1,  3'd0, 8'h01};
    tbl[12] = '{1'b0, 3,  3'd0, 8'h01};
    tbl[13] = '{1'b0, 1,  3'd1, 8'h01};
    tbl[14] = '{1'b0, 28, 3'd0, 8'h02};
    tbl[15] = '{1'b0, 224, 3'd0, 8'h01}; // full rotation from previous step back to 01? see below

`ifdef SEQ_PINGPONG_EN
    walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    // ping-pong after 224 more edges from step 1: step 8 -> 40
    tbl[15] = '{1'b0, 224, 3'd0, 8'h40};
`else
    walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
             8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    tbl[15] = '{1'b0, 224, 3'd0, 8'h01};  // step 8 wraps to bit0
`endif

    for (int i = 0; i < 16; i++) begin
      rst4 = tbl[i].rst;
      for (int e = 0; e < tbl[i].edges; e++) begin
        @(posedge clk);
        #1;
        if (tbl[i].rst) begin
          check($sformatf("v%0d_rst_tick", i), tick4, 0);
          check($sformatf("v%0d_rst_sel", i), sel4, 8'h01);
        end
      end
      check($sformatf("v%0d_tick", i), tick4, tbl[i].tick);
      check($sformatf("v%0d_sel", i), sel4, tbl[i].sel);
    end

    // PRESCALE=1 walk: tick follows edge count mod 8, sel steps every 8 edges
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    check("walk_e0_tick", tick1, 0);
    check("walk_e0_sel", sel1, 8'h01);
    for (int e = 1; e <= 112; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("walk_e%0d_tick", e), tick1, e % 8);
      check($sformatf("walk_e%0d_sel", e), sel1, walk[e / 8]);
      check($sformatf("walk_e%0d_onehot", e), $countones(sel1), 1);
    end

    // mid-walk reset on the PRESCALE=1 instance
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    check("walk_rst_tick", tick1, 0);
    check("walk_rst_sel", sel1, 8'h01);
    @(posedge clk);
    #1;
    check("walk_rel_tick", tick1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
